// File: rtl/timer_ctrl_pkg.sv
// Purpose: shared constants and types for the 8051 timer/counter block.
// Latency: none (declarations only).
// Backpressure: none.
package timer_pkg;

  // clk cycles per machine cycle
  localparam int PRESCALE = 12;
  localparam int PRESC_W  = $clog2(PRESCALE);

  // SFR addresses
  localparam logic [7:0] ADDR_TCON = 8'h88;
  localparam logic [7:0] ADDR_TMOD = 8'h89;
  localparam logic [7:0] ADDR_TL0  = 8'h8A;
  localparam logic [7:0] ADDR_TL1  = 8'h8B;
  localparam logic [7:0] ADDR_TH0  = 8'h8C;
  localparam logic [7:0] ADDR_TH1  = 8'h8D;

  // TMOD field positions inside one timer nibble
  localparam int TMOD_GATE = 3;
  localparam int TMOD_CT   = 2;
  localparam int TMOD_M1   = 1;
  localparam int TMOD_M0   = 0;

  // TCON flag/run bit positions
  localparam int TCON_TF1 = 7;
  localparam int TCON_TR1 = 6;
  localparam int TCON_TF0 = 5;
  localparam int TCON_TR0 = 4;

  typedef enum logic [1:0] {
    MODE13       = 2'd0,
    MODE16       = 2'd1,
    MODE8_RELOAD = 2'd2,
    MODE_SPLIT   = 2'd3
  } mode_e;

  // Extract the mode field from a TMOD nibble
  function automatic mode_e nib_mode(input logic [3:0] nib);
    return mode_e'({nib[TMOD_M1], nib[TMOD_M0]});
  endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Purpose: internal SFR bus between the CPU core and the timer block.
// Latency: read data is combinational; writes land on the next clk edge.
// Backpressure: none; every strobe is accepted in its cycle.
interface timer_ctrl_if;
  logic [7:0] sfr_addr;
  logic       sfr_wr;
  logic [7:0] sfr_wdata;
  logic       sfr_rd;
  logic [7:0] sfr_rdata;
  logic       sfr_hit;

  modport master (
    output sfr_addr, sfr_wr, sfr_wdata, sfr_rd,
    input  sfr_rdata, sfr_hit
  );

  modport slave (
    input  sfr_addr, sfr_wr, sfr_wdata, sfr_rd,
    output sfr_rdata, sfr_hit
  );
endinterface

// File: rtl/timer_ctrl_unit.sv
// Purpose: one TL/TH counter pair with mode 0-3 counting, reload and pin edge detect.
// Latency: count updates on the edge ending the tick cycle; overflow is a same-cycle pulse.
// Backpressure: none; a register write in the same cycle drops that increment.
module timer_unit
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  mode_e      mode,
  input  logic       run,
  input  logic       ct,
  input  logic       th_run,
  input  logic       pin_sync,
  input  logic       wr_tl,
  input  logic       wr_th,
  input  logic [7:0] wdata,
  output logic [7:0] tl,
  output logic [7:0] th,
  output logic       ovf,
  output logic       th_ovf
);

  logic       pin_samp;
  logic       edge_evt;
  logic       inc;
  logic       th_inc;
  logic       any_wr;
  logic [7:0] tl_nxt;
  logic [7:0] th_nxt;

  // Pin is re-sampled once per machine cycle; edges are judged tick to tick
  always_ff @(posedge clk) begin
    if (rst)       pin_samp <= 1'b1;
    else if (tick) pin_samp <= pin_sync;
  end

  assign edge_evt = pin_samp & ~pin_sync;
  assign inc      = run & tick & (~ct | edge_evt);
  // Split-mode upper byte is always a timer, never a counter
  assign th_inc   = th_run & tick;
  assign any_wr   = wr_tl | wr_th;

  // Next count and overflow pulse for the selected mode
  always_comb begin
    tl_nxt = tl;
    th_nxt = th;
    ovf    = 1'b0;
    th_ovf = 1'b0;
    case (mode)
      MODE13: begin
        if (inc && !any_wr) begin
          tl_nxt[4:0] = tl[4:0] + 5'd1;
          if (tl[4:0] == 5'h1F) begin
            th_nxt = th + 8'd1;
            ovf    = (th == 8'hFF);
          end
        end
      end
      MODE16: begin
        if (inc && !any_wr) begin
          {th_nxt, tl_nxt} = {th, tl} + 16'd1;
          ovf              = ({th, tl} == 16'hFFFF);
        end
      end
      MODE8_RELOAD: begin
        if (inc && !any_wr) begin
          if (tl == 8'hFF) begin
            tl_nxt = th;
            ovf    = 1'b1;
          end else begin
            tl_nxt = tl + 8'd1;
          end
        end
      end
      MODE_SPLIT: begin
        // The two halves are independent counters here, so only the
        // written half loses its increment
        if (inc && !wr_tl) begin
          tl_nxt = tl + 8'd1;
          ovf    = (tl == 8'hFF);
        end
        if (th_inc && !wr_th) begin
          th_nxt = th + 8'd1;
          th_ovf = (th == 8'hFF);
        end
      end
      default: ;
    endcase
  end

  // Count registers: software writes take priority over counting
  always_ff @(posedge clk) begin
    if (rst) begin
      tl <= 8'h00;
      th <= 8'h00;
    end else begin
      tl <= wr_tl ? wdata : tl_nxt;
      th <= wr_th ? wdata : th_nxt;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Purpose: 8051 timer/counter controller: prescaler, TCON/TMOD, run/gate, mode-3 steering, SFR reads.
// Latency: writes visible next cycle; TF rises the cycle after the overflowing tick.
// Backpressure: none; SFR accesses and acks are taken every cycle.
module timer_ctrl
  import timer_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  timer_ctrl_if.slave   sfr,
  input  logic          t0_pin,
  input  logic          t1_pin,
  input  logic          int0_n,
  input  logic          int1_n,
  output logic          tick,
  output logic          tf0_irq,
  output logic          tf1_irq,
  input  logic          irq_ack0,
  input  logic          irq_ack1
);

  logic [PRESC_W-1:0] presc_cnt;
  logic [1:0]         t0_s, t1_s, i0_s, i1_s;
  logic [7:0]         tcon, tmod;
  logic [7:0]         tl0, th0, tl1, th1;
  logic [7:0]         rd_val;
  logic               hit;
  logic               wr_tcon, wr_tmod, wr_tl0, wr_th0, wr_tl1, wr_th1;
  mode_e              mode0, mode1;
  logic               t0_split, t1_split;
  logic               run0, run1, th0_run;
  logic               u0_ovf, u0_th_ovf, u1_ovf, u1_th_ovf;
  logic               tf0_set, tf1_set;

  assign tick = (presc_cnt == PRESC_W'(PRESCALE - 1));

  // Machine-cycle prescaler, free running 0..PRESCALE-1
  always_ff @(posedge clk) begin
    if (rst)       presc_cnt <= '0;
    else if (tick) presc_cnt <= '0;
    else           presc_cnt <= presc_cnt + 1'b1;
  end

  // Two-flop synchronizers for the asynchronous pins and gate inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      t0_s <= 2'b11;
      t1_s <= 2'b11;
      i0_s <= 2'b11;
      i1_s <= 2'b11;
    end else begin
      t0_s <= {t0_s[0], t0_pin};
      t1_s <= {t1_s[0], t1_pin};
      i0_s <= {i0_s[0], int0_n};
      i1_s <= {i1_s[0], int1_n};
    end
  end

  assign wr_tcon = sfr.sfr_wr && (sfr.sfr_addr == ADDR_TCON);
  assign wr_tmod = sfr.sfr_wr && (sfr.sfr_addr == ADDR_TMOD);
  assign wr_tl0  = sfr.sfr_wr && (sfr.sfr_addr == ADDR_TL0);
  assign wr_th0  = sfr.sfr_wr && (sfr.sfr_addr == ADDR_TH0);
  assign wr_tl1  = sfr.sfr_wr && (sfr.sfr_addr == ADDR_TL1);
  assign wr_th1  = sfr.sfr_wr && (sfr.sfr_addr == ADDR_TH1);

  assign mode0    = nib_mode(tmod[3:0]);
  assign mode1    = nib_mode(tmod[7:4]);
  assign t0_split = (mode0 == MODE_SPLIT);
  assign t1_split = (mode1 == MODE_SPLIT);

  // Timer 1 in mode 3 is parked; TR1 then only drives TH0 when timer 0 is split
  assign run0    = tcon[TCON_TR0] & (~tmod[TMOD_GATE] | i0_s[1]);
  assign run1    = tcon[TCON_TR1] & (~tmod[4 + TMOD_GATE] | i1_s[1]) & ~t1_split;
  assign th0_run = tcon[TCON_TR1] & t0_split;

  timer_unit u_t0 (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .mode     (mode0),
    .run      (run0),
    .ct       (tmod[TMOD_CT]),
    .th_run   (th0_run),
    .pin_sync (t0_s[1]),
    .wr_tl    (wr_tl0),
    .wr_th    (wr_th0),
    .wdata    (sfr.sfr_wdata),
    .tl       (tl0),
    .th       (th0),
    .ovf      (u0_ovf),
    .th_ovf   (u0_th_ovf)
  );

  timer_unit u_t1 (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .mode     (mode1),
    .run      (run1),
    .ct       (tmod[4 + TMOD_CT]),
    .th_run   (1'b0),
    .pin_sync (t1_s[1]),
    .wr_tl    (wr_tl1),
    .wr_th    (wr_th1),
    .wdata    (sfr.sfr_wdata),
    .tl       (tl1),
    .th       (th1),
    .ovf      (u1_ovf),
    .th_ovf   (u1_th_ovf)
  );

  // While timer 0 is split, TF1 belongs to TH0 and timer 1 overflows are silent.
  // u1_th_ovf is structurally zero (its th_run is tied low).
  assign tf0_set = u0_ovf;
  assign tf1_set = t0_split ? u0_th_ovf : (u1_ovf | u1_th_ovf);

  // TCON: overflow set wins over ack and software clear; other bits follow writes
  always_ff @(posedge clk) begin
    if (rst) begin
      tcon <= 8'h00;
    end else begin
      if (wr_tcon) begin
        tcon[TCON_TR1] <= sfr.sfr_wdata[TCON_TR1];
        tcon[TCON_TR0] <= sfr.sfr_wdata[TCON_TR0];
        tcon[3:0]      <= sfr.sfr_wdata[3:0];
      end
      if (tf0_set)       tcon[TCON_TF0] <= 1'b1;
      else if (wr_tcon)  tcon[TCON_TF0] <= sfr.sfr_wdata[TCON_TF0];
      else if (irq_ack0) tcon[TCON_TF0] <= 1'b0;
      if (tf1_set)       tcon[TCON_TF1] <= 1'b1;
      else if (wr_tcon)  tcon[TCON_TF1] <= sfr.sfr_wdata[TCON_TF1];
      else if (irq_ack1) tcon[TCON_TF1] <= 1'b0;
    end
  end

  // TMOD holds whatever software last wrote
  always_ff @(posedge clk) begin
    if (rst)          tmod <= 8'h00;
    else if (wr_tmod) tmod <= sfr.sfr_wdata;
  end

  assign tf0_irq = tcon[TCON_TF0];
  assign tf1_irq = tcon[TCON_TF1];

  // SFR read mux and address decode
  always_comb begin
    rd_val = 8'h00;
    hit    = 1'b1;
    case (sfr.sfr_addr)
      ADDR_TCON: rd_val = tcon;
      ADDR_TMOD: rd_val = tmod;
      ADDR_TL0:  rd_val = tl0;
      ADDR_TL1:  rd_val = tl1;
      ADDR_TH0:  rd_val = th0;
      ADDR_TH1:  rd_val = th1;
      default:   hit    = 1'b0;
    endcase
  end

  assign sfr.sfr_hit   = hit;
  assign sfr.sfr_rdata = sfr.sfr_rd ? rd_val : 8'h00;

endmodule

// File: tb/tb_timer_ctrl.sv
// Purpose: directed check of timer_ctrl modes, gating, counting, collisions and reset.
// Latency: inputs driven on negedge, outputs sampled on negedge (+1 for reads).
// Backpressure: none.
module tb_timer_ctrl;
  import timer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic t0_pin = 1'b1, t1_pin = 1'b1, int0_n = 1'b1, int1_n = 1'b1;
  logic irq_ack0 = 1'b0, irq_ack1 = 1'b0;
  logic tick, tf0_irq, tf1_irq;

  int n_assert = 0;
  int n_fail   = 0;

  timer_ctrl_if sfr_bus();

  timer_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .sfr      (sfr_bus),
    .t0_pin   (t0_pin),
    .t1_pin   (t1_pin),
    .int0_n   (int0_n),
    .int1_n   (int1_n),
    .tick     (tick),
    .tf0_irq  (tf0_irq),
    .tf1_irq  (tf1_irq),
    .irq_ack0 (irq_ack0),
    .irq_ack1 (irq_ack1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sfr_write(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    sfr_bus.sfr_addr  = addr;
    sfr_bus.sfr_wdata = data;
    sfr_bus.sfr_wr    = 1'b1;
    @(negedge clk);
    sfr_bus.sfr_wr    = 1'b0;
    sfr_bus.sfr_addr  = 8'h00;
  endtask

  task automatic sfr_read(input logic [7:0] addr, output logic [7:0] data);
    sfr_bus.sfr_addr = addr;
    sfr_bus.sfr_rd   = 1'b1;
    #1;
    data = sfr_bus.sfr_rdata;
    sfr_bus.sfr_rd   = 1'b0;
    sfr_bus.sfr_addr = 8'h00;
  endtask

  task automatic check_reg(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    logic [7:0] d;
    sfr_read(addr, d);
    check(tag, {8'h00, d}, {8'h00, exp});
  endtask

  // Park on the negedge inside a tick cycle (bounded)
  task automatic wait_tick_cycle();
    int g = 0;
    while (!tick && g < 4 * PRESCALE) begin
      @(negedge clk);
      g++;
    end
    if (!tick) check("tick_timeout", 16'd0, 16'd1);
  endtask

  // Let n ticks take effect; returns on the negedge just after the last one
  task automatic wait_ticks(input int n);
    repeat (n) begin
      wait_tick_cycle();
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [7:0] d;
    sfr_bus.sfr_addr  = 8'h00;
    sfr_bus.sfr_wdata = 8'h00;
    sfr_bus.sfr_wr    = 1'b0;
    sfr_bus.sfr_rd    = 1'b0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_tick", {15'd0, tick}, 16'd0);
    check("rst_tf0", {15'd0, tf0_irq}, 16'd0);
    check("rst_tf1", {15'd0, tf1_irq}, 16'd0);
    check_reg("rst_tcon", ADDR_TCON, 8'h00);
    check_reg("rst_tmod", ADDR_TMOD, 8'h00);
    check_reg("rst_th1", ADDR_TH1, 8'h00);
    sfr_bus.sfr_addr = ADDR_TMOD;
    #1;
    check("hit_tmod", {15'd0, sfr_bus.sfr_hit}, 16'd1);
    check("rdata_no_rd", {8'h00, sfr_bus.sfr_rdata}, 16'h0000);
    sfr_bus.sfr_addr = 8'h90;
    #1;
    check("hit_miss", {15'd0, sfr_bus.sfr_hit}, 16'd0);
    sfr_bus.sfr_addr = 8'h00;

    // ---- first tick: counter starts at 0, tick when it reaches 11 ----
    @(negedge clk);
    rst = 1'b0;
    c = 0;
    while (!tick && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("first_tick_edges", 16'(c), 16'd11);
    c = 0;
    @(negedge clk);
    while (!tick && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("tick_period", 16'(c + 1), 16'd12);

    // ---- unmapped address ignored ----
    sfr_write(8'h90, 8'hFF);
    check_reg("ignored_tmod", ADDR_TMOD, 8'h00);
    check_reg("ignored_tcon", ADDR_TCON, 8'h00);
    sfr_read(8'h90, d);
    check("ignored_rdata", {8'h00, d}, 16'h0000);

    // ---- mode 1 ----
    sfr_write(ADDR_TMOD, 8'h01);
    sfr_write(ADDR_TH0, 8'hFF);
    sfr_write(ADDR_TL0, 8'hFE);
    sfr_write(ADDR_TCON, 8'h10);
    wait_ticks(2);
    check_reg("m1_th0", ADDR_TH0, 8'h00);
    check_reg("m1_tl0", ADDR_TL0, 8'h00);
    check("m1_tf0", {15'd0, tf0_irq}, 16'd1);
    check_reg("m1_tcon", ADDR_TCON, 8'h30);
    irq_ack0 = 1'b1;
    @(negedge clk);
    irq_ack0 = 1'b0;
    check("m1_ack_tf0", {15'd0, tf0_irq}, 16'd0);
    check_reg("m1_ack_tcon", ADDR_TCON, 8'h10);
    sfr_write(ADDR_TCON, 8'h00);

    // ---- mode 2 auto-reload on timer 1 ----
    sfr_write(ADDR_TMOD, 8'h20);
    sfr_write(ADDR_TH1, 8'hF0);
    sfr_write(ADDR_TL1, 8'hFE);
    sfr_write(ADDR_TCON, 8'h40);
    wait_ticks(2);
    check_reg("m2_tl1_reload", ADDR_TL1, 8'hF0);
    check_reg("m2_th1_kept", ADDR_TH1, 8'hF0);
    check("m2_tf1", {15'd0, tf1_irq}, 16'd1);
    irq_ack1 = 1'b1;
    @(negedge clk);
    irq_ack1 = 1'b0;
    check("m2_ack_tf1", {15'd0, tf1_irq}, 16'd0);
    wait_ticks(15);
    check("m2_tf1_t15", {15'd0, tf1_irq}, 16'd0);
    check_reg("m2_tl1_t15", ADDR_TL1, 8'hFF);
    wait_ticks(1);
    check("m2_tf1_t16", {15'd0, tf1_irq}, 16'd1);
    check_reg("m2_tl1_t16", ADDR_TL1, 8'hF0);
    sfr_write(ADDR_TCON, 8'h00);

    // ---- gate ----
    int0_n = 1'b0;
    sfr_write(ADDR_TMOD, 8'h09);
    sfr_write(ADDR_TL0, 8'h00);
    sfr_write(ADDR_TH0, 8'h00);
    sfr_write(ADDR_TCON, 8'h10);
    wait_ticks(10);
    check_reg("gate_closed_tl0", ADDR_TL0, 8'h00);
    int0_n = 1'b1;
    wait_ticks(5);
    check_reg("gate_open_tl0", ADDR_TL0, 8'h05);
    sfr_write(ADDR_TCON, 8'h00);

    // ---- counter mode on t0_pin ----
    sfr_write(ADDR_TMOD, 8'h05);
    sfr_write(ADDR_TL0, 8'h00);
    sfr_write(ADDR_TH0, 8'h00);
    sfr_write(ADDR_TCON, 8'h10);
    repeat (3) begin
      t0_pin = 1'b0;
      repeat (30) @(negedge clk);
      t0_pin = 1'b1;
      repeat (30) @(negedge clk);
    end
    check_reg("cnt_tl0_3", ADDR_TL0, 8'h03);
    // Short pulses placed right after a tick so no tick samples them low
    repeat (2) begin
      wait_ticks(1);
      t0_pin = 1'b0;
      repeat (4) @(negedge clk);
      t0_pin = 1'b1;
    end
    wait_ticks(2);
    check_reg("cnt_short_tl0", ADDR_TL0, 8'h03);
    sfr_write(ADDR_TCON, 8'h00);

    // ---- write beats increment ----
    sfr_write(ADDR_TMOD, 8'h01);
    sfr_write(ADDR_TH0, 8'h00);
    sfr_write(ADDR_TL0, 8'h00);
    sfr_write(ADDR_TCON, 8'h10);
    wait_tick_cycle();
    sfr_bus.sfr_addr  = ADDR_TL0;
    sfr_bus.sfr_wdata = 8'h55;
    sfr_bus.sfr_wr    = 1'b1;
    @(negedge clk);
    sfr_bus.sfr_wr    = 1'b0;
    sfr_bus.sfr_addr  = 8'h00;
    check_reg("coll_wr_tl0", ADDR_TL0, 8'h55);
    wait_ticks(1);
    check_reg("coll_next_tl0", ADDR_TL0, 8'h56);

    // ---- overflow beats ack ----
    sfr_write(ADDR_TCON, 8'h00);
    sfr_write(ADDR_TH0, 8'hFF);
    sfr_write(ADDR_TL0, 8'hFF);
    sfr_write(ADDR_TCON, 8'h10);
    wait_tick_cycle();
    irq_ack0 = 1'b1;
    @(negedge clk);
    irq_ack0 = 1'b0;
    check("coll_ack_tf0", {15'd0, tf0_irq}, 16'd1);
    check_reg("coll_ack_tl0", ADDR_TL0, 8'h00);
    sfr_write(ADDR_TCON, 8'h10);
    check("sw_clear_tf0", {15'd0, tf0_irq}, 16'd0);
    sfr_write(ADDR_TCON, 8'h00);

    // ---- mode 3: TH0 runs from TR1 and owns TF1, timer 1 parked ----
    sfr_write(ADDR_TMOD, 8'h33);
    sfr_write(ADDR_TL0, 8'h12);
    sfr_write(ADDR_TH0, 8'hFF);
    sfr_write(ADDR_TL1, 8'h34);
    sfr_write(ADDR_TH1, 8'h56);
    sfr_write(ADDR_TCON, 8'h40);
    wait_ticks(1);
    check_reg("m3_th0", ADDR_TH0, 8'h00);
    check("m3_tf1", {15'd0, tf1_irq}, 16'd1);
    check("m3_tf0", {15'd0, tf0_irq}, 16'd0);
    check_reg("m3_tl0", ADDR_TL0, 8'h12);
    check_reg("m3_tl1", ADDR_TL1, 8'h34);
    check_reg("m3_th1", ADDR_TH1, 8'h56);

    // ---- mode 3 on T0, timer 1 in mode 0 counts but cannot set TF1 ----
    sfr_write(ADDR_TCON, 8'h00);
    sfr_write(ADDR_TMOD, 8'h03);
    sfr_write(ADDR_TH1, 8'hFF);
    sfr_write(ADDR_TL1, 8'h1F);
    sfr_write(ADDR_TH0, 8'h10);
    sfr_write(ADDR_TCON, 8'h40);
    wait_ticks(1);
    check_reg("m3b_tl1", ADDR_TL1, 8'h00);
    check_reg("m3b_th1", ADDR_TH1, 8'h00);
    check_reg("m3b_th0", ADDR_TH0, 8'h11);
    check("m3b_tf1", {15'd0, tf1_irq}, 16'd0);

    // ---- reset mid-run drops pending flags ----
    sfr_write(ADDR_TCON, 8'h60);
    check("sw_set_tf0", {15'd0, tf0_irq}, 16'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rerst_tf0", {15'd0, tf0_irq}, 16'd0);
    check_reg("rerst_tcon", ADDR_TCON, 8'h00);
    check_reg("rerst_th0", ADDR_TH0, 8'h00);
    check_reg("rerst_tmod", ADDR_TMOD, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
